// File: rtl/pick_collision_detector_if.sv
// Pixel-stream inputs and collision-result slot of the pick collision detector.
// The master side is the pixel scanner / game logic, the slave side is the detector.
interface pick_collision_detector_if #(
  parameter int CNT_W = 19
);
  // Pixel stream from the renderer
  logic             frame_start;
  logic             pixel_en;
  logic [9:0]       drawX;
  logic [9:0]       drawY;
  logic             showPick;
  logic             showTarget;

  // Per-frame result slot towards game logic
  logic             hit_valid;
  logic             hit_ready;
  logic             hit_flag;
  logic [CNT_W-1:0] hit_count;
  logic [9:0]       first_x;
  logic [9:0]       first_y;
  logic [7:0]       drop_count;

  modport master (
    output frame_start, pixel_en, drawX, drawY, showPick, showTarget, hit_ready,
    input  hit_valid, hit_flag, hit_count, first_x, first_y, drop_count
  );

  modport slave (
    input  frame_start, pixel_en, drawX, drawY, showPick, showTarget, hit_ready,
    output hit_valid, hit_flag, hit_count, first_x, first_y, drop_count
  );
endinterface

// File: rtl/pick_collision_detector.sv
// Pick collision detector: counts pick/target overlap pixels over one scanned
// frame, remembers the first overlap in raster order, and publishes one result
// per frame through a single valid/ready slot. Frames that finish while the
// slot is still occupied are dropped and counted.
module pick_collision_detector #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int MIN_OVERLAP = 4,
  parameter int CNT_W       = 19
) (
  input logic                     CLK,
  input logic                     Reset_n,
  pick_collision_detector_if.slave pick
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_HIT   = CNT_W'(MIN_OVERLAP);
  localparam logic [9:0]       NO_COORD  = 10'h3FF;
  localparam logic [10:0]      H_LIMIT   = 11'(H_ACTIVE);
  localparam logic [10:0]      V_LIMIT   = 11'(V_ACTIVE);
  localparam logic [9:0]       X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       Y_LAST    = 10'(V_ACTIVE - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } scanState_t;

  scanState_t       scanState;
  logic [CNT_W-1:0] accCount;
  logic [9:0]       accX;
  logic [9:0]       accY;

  logic             hitValid;
  logic             hitFlag;
  logic [CNT_W-1:0] hitCount;
  logic [9:0]       firstX;
  logic [9:0]       firstY;
  logic [7:0]       dropCount;

  logic             inFrame;
  logic             qualify;
  logic             overlap;
  logic             lastPixel;
  logic             handshake;
  logic [CNT_W-1:0] baseCount;
  logic [9:0]       baseX;
  logic [9:0]       baseY;
  logic [CNT_W-1:0] nextCount;
  logic [9:0]       nextX;
  logic [9:0]       nextY;
  logic             nextFlag;

  // Accumulator next-state; a frame_start restarts the frame before the
  // coincident pixel is accounted, so that pixel belongs to the new frame.
  always_comb begin
    inFrame   = (scanState == SCAN) || pick.frame_start;
    qualify   = pick.pixel_en
              && ({1'b0, pick.drawX} < H_LIMIT)
              && ({1'b0, pick.drawY} < V_LIMIT);
    overlap   = inFrame && qualify && pick.showPick && pick.showTarget;
    lastPixel = inFrame && qualify && (pick.drawX == X_LAST) && (pick.drawY == Y_LAST);
    handshake = hitValid && pick.hit_ready;

    baseCount = pick.frame_start ? '0 : accCount;
    baseX     = pick.frame_start ? NO_COORD : accX;
    baseY     = pick.frame_start ? NO_COORD : accY;

    nextCount = baseCount;
    nextX     = baseX;
    nextY     = baseY;
    if (overlap) begin
      if (baseCount != CNT_MAX) begin
        nextCount = baseCount + 1'b1;
      end
      if (baseCount == '0) begin
        nextX = pick.drawX;
        nextY = pick.drawY;
      end
    end
    nextFlag = (nextCount >= CNT_HIT);
  end

  // Scan FSM with the per-frame accumulator
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      scanState <= IDLE;
      accCount  <= '0;
      accX      <= NO_COORD;
      accY      <= NO_COORD;
    end else begin
      if (inFrame) begin
        accCount <= nextCount;
        accX     <= nextX;
        accY     <= nextY;
      end
      unique case (scanState)
        IDLE: begin
          if (pick.frame_start) begin
            scanState <= lastPixel ? IDLE : SCAN;
          end
        end
        SCAN: begin
          if (lastPixel) begin
            scanState <= IDLE;
          end
        end
        default: scanState <= IDLE;
      endcase
    end
  end

  // Result slot: load on frame end when free (or freeing this cycle), else drop
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      hitValid  <= 1'b0;
      hitFlag   <= 1'b0;
      hitCount  <= '0;
      firstX    <= NO_COORD;
      firstY    <= NO_COORD;
      dropCount <= '0;
    end else begin
      if (lastPixel && (!hitValid || handshake)) begin
        hitValid <= 1'b1;
        hitFlag  <= nextFlag;
        hitCount <= nextCount;
        firstX   <= nextX;
        firstY   <= nextY;
      end else begin
        if (lastPixel && (dropCount != 8'hFF)) begin
          dropCount <= dropCount + 8'd1;
        end
        if (handshake) begin
          hitValid <= 1'b0;
        end
      end
    end
  end

  assign pick.hit_valid  = hitValid;
  assign pick.hit_flag   = hitFlag;
  assign pick.hit_count  = hitCount;
  assign pick.first_x    = firstX;
  assign pick.first_y    = firstY;
  assign pick.drop_count = dropCount;

endmodule

// File: tb/tb_pick_collision_detector.sv
// Directed bench for pick_collision_detector on a small 8x4 frame. Each frame's
// expected result is computed from the bench's own pick/target maps and queued;
// it is popped and compared when the slot presents it.
module tb_pick_collision_detector;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 19;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pick_collision_detector_if #(.CNT_W(CW)) pif ();

  pick_collision_detector #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MIN_OVERLAP(4), .CNT_W(CW)
  ) dut (
    .CLK(clk),
    .Reset_n(rst_n),
    .pick(pif)
  );

  typedef struct packed {
    logic          flag;
    logic [CW-1:0] count;
    logic [9:0]    x;
    logic [9:0]    y;
  } res_t;

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   pickMap[V][H];
  bit   targetMap[V][H];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_valid"}, 32'(pif.hit_valid), 32'd0);
    check({tag, "_flag"},  32'(pif.hit_flag),  32'd0);
    check({tag, "_count"}, 32'(pif.hit_count), 32'd0);
    check({tag, "_fx"},    32'(pif.first_x),   32'h3FF);
    check({tag, "_fy"},    32'(pif.first_y),   32'h3FF);
    check({tag, "_drop"},  32'(pif.drop_count), 32'd0);
  endtask

  task automatic clearMaps();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        pickMap[y][x]   = 1'b0;
        targetMap[y][x] = 1'b0;
      end
    end
  endtask

  task automatic setOvl(input int x, input int y);
    pickMap[y][x]   = 1'b1;
    targetMap[y][x] = 1'b1;
  endtask

  // Reference result of a frame whose counting starts at raster index startIdx
  function automatic res_t model(input int startIdx);
    res_t r;
    int   cnt;
    cnt = 0;
    r.x = 10'h3FF;
    r.y = 10'h3FF;
    for (int idx = startIdx; idx < NPIX; idx++) begin
      if (pickMap[idx / H][idx % H] && targetMap[idx / H][idx % H]) begin
        if (cnt == 0) begin
          r.x = 10'(idx % H);
          r.y = 10'(idx / H);
        end
        cnt++;
      end
    end
    r.count = CW'(cnt);
    r.flag  = (cnt >= 4);
    return r;
  endfunction

  task automatic drivePixel(input int x, input int y, input bit p, input bit t, input bit fs);
    pif.pixel_en    = 1'b1;
    pif.drawX       = 10'(x);
    pif.drawY       = 10'(y);
    pif.showPick    = p;
    pif.showTarget  = t;
    pif.frame_start = fs;
    step();
    pif.frame_start = 1'b0;
  endtask

  // Scan the maps in raster order. abortIdx: pixel carrying a coincident
  // frame_start; stopIdx: pixels driven; oob: interleave out-of-range overlaps.
  task automatic scanFrame(input int abortIdx, input int stopIdx, input bit readyOnLast,
                           input bit oob, input bit withStart);
    if (withStart) begin
      pif.frame_start = 1'b1;
      pif.pixel_en    = 1'b0;
      step();
      pif.frame_start = 1'b0;
    end
    for (int idx = 0; idx < stopIdx; idx++) begin
      if (idx == NPIX - 1 && readyOnLast) pif.hit_ready = 1'b1;
      drivePixel(idx % H, idx / H, pickMap[idx / H][idx % H], targetMap[idx / H][idx % H],
                 idx == abortIdx);
      if (oob && (idx % H) == H - 1 && (idx / H) < V - 1) begin
        drivePixel(H, idx / H, 1'b1, 1'b1, 1'b0);
        drivePixel(1023, idx / H, 1'b1, 1'b1, 1'b0);
        drivePixel(0, V, 1'b1, 1'b1, 1'b0);
      end
    end
    pif.pixel_en   = 1'b0;
    pif.showPick   = 1'b0;
    pif.showTarget = 1'b0;
  endtask

  task automatic compareSlot(input string tag, input res_t r);
    check({tag, "_valid"}, 32'(pif.hit_valid), 32'd1);
    check({tag, "_count"}, 32'(pif.hit_count), 32'(r.count));
    check({tag, "_flag"},  32'(pif.hit_flag),  32'(r.flag));
    check({tag, "_fx"},    32'(pif.first_x),   32'(r.x));
    check({tag, "_fy"},    32'(pif.first_y),   32'(r.y));
  endtask

  task automatic expectSlot(input string tag);
    res_t r;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty scoreboard expected a result", tag);
    end
    if (sb.size() != 0) begin
      r = sb.pop_front();
      compareSlot(tag, r);
      $display("[TB] %s: result count=%0d flag=%0d first=(%0d,%0d) drop=%0d",
               tag, pif.hit_count, pif.hit_flag, pif.first_x, pif.first_y, pif.drop_count);
    end
  endtask

  task automatic expectHeld(input string tag);
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty scoreboard expected a result", tag);
    end
    if (sb.size() != 0) begin
      compareSlot(tag, sb[0]);
      $display("[TB] %s: held count=%0d drop=%0d", tag, pif.hit_count, pif.drop_count);
    end
  endtask

  initial begin
    pif.frame_start = 1'b0;
    pif.pixel_en    = 1'b0;
    pif.drawX       = '0;
    pif.drawY       = '0;
    pif.showPick    = 1'b0;
    pif.showTarget  = 1'b0;
    pif.hit_ready   = 1'b0;
    clearMaps();

    // Reset state
    repeat (3) step();
    checkReset("por");
    rst_n = 1'b1;
    step();

    // 1. Full-overlap frame held, then reset in the middle of the next scan
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) setOvl(x, y);
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectSlot("t1_full");
    scanFrame(-1, 20, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    checkReset("t1_midreset");
    step();
    rst_n = 1'b1;
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b0);
    step();
    check("t1_idle_ignored", 32'(pif.hit_valid), 32'd0);

    // 2. Single frame at threshold, consumer always ready
    clearMaps();
    setOvl(2, 1); setOvl(3, 1); setOvl(4, 1); setOvl(2, 2);
    pickMap[0][0] = 1'b1;
    targetMap[3][7] = 1'b1;
    pif.hit_ready = 1'b1;
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectSlot("t2_frame");
    step();
    check("t2_valid_drop", 32'(pif.hit_valid), 32'd0);

    // 3. Below threshold, then zero-overlap frame
    clearMaps();
    setOvl(5, 0); setOvl(1, 3); setOvl(6, 3);
    pickMap[0][0] = 1'b1; targetMap[0][7] = 1'b1; pickMap[2][4] = 1'b1;
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectSlot("t3_below");
    step();
    clearMaps();
    pickMap[1][1] = 1'b1; targetMap[1][2] = 1'b1;
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectSlot("t3_zero");
    step();

    // 4. Backpressure across three frames, reload on the fourth
    pif.hit_ready = 1'b0;
    clearMaps();
    for (int x = 1; x <= 5; x++) setOvl(x, 0);
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectHeld("t4_f1");
    clearMaps(); setOvl(0, 3);
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    expectHeld("t4_f2");
    clearMaps(); setOvl(6, 3); setOvl(7, 3);
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    expectSlot("t4_f3");
    check("t4_drop2", 32'(pif.drop_count), 32'd2);
    clearMaps();
    for (int x = 3; x <= 7; x++) setOvl(x, 2);
    setOvl(0, 3);
    scanFrame(-1, NPIX, 1'b1, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectSlot("t4_f4");
    check("t4_drop_kept", 32'(pif.drop_count), 32'd2);
    step();
    check("t4_consumed", 32'(pif.hit_valid), 32'd0);

    // 5. Abort at (5,2) with a coincident pixel, then last-pixel-only overlap
    clearMaps();
    for (int x = 0; x <= 5; x++) setOvl(x, 0);
    setOvl(5, 2); setOvl(7, 3);
    scanFrame(2 * H + 5, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(2 * H + 5));
    expectSlot("t5_abort");
    step();
    check("t5_single_result", 32'(pif.hit_valid), 32'd0);
    clearMaps(); setOvl(7, 3);
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    expectSlot("t5_lastpix");
    step();

    // 6. Out-of-range overlaps ignored; drop counter saturation
    clearMaps(); setOvl(0, 1);
    scanFrame(-1, NPIX, 1'b0, 1'b1, 1'b1);
    sb.push_back(model(0));
    expectSlot("t6_oob");
    step();
    pif.hit_ready = 1'b0;
    clearMaps(); setOvl(2, 2);
    scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(0));
    clearMaps();
    repeat (252) scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    check("t6_drop254", 32'(pif.drop_count), 32'd254);
    repeat (48) scanFrame(-1, NPIX, 1'b0, 1'b0, 1'b1);
    check("t6_drop_sat", 32'(pif.drop_count), 32'd255);
    expectSlot("t6_held");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
